// File: rtl/pipo_pkg.sv
// Shared definitions for the pipo_arbiter slice: FSM state encoding and
// the default requester count / register width.
package pipo_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 4;

  // One transaction walks IDLE -> GRANT -> ACK -> IDLE (three cycles).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

endpackage

// File: rtl/pipo_reg.sv
// Shared parallel-in/parallel-out storage register.
//   clk     : clock, all updates on posedge
//   clear_n : synchronous active-low reset, zeroes q
//   load    : load d into q at next edge
//   zero    : zero q at next edge (takes priority over load)
//   d       : parallel data in
//   q       : register contents
module pipo_reg
  import pipo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             load,
  input  logic             zero,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: reset is sampled inside the clocked block, so it is synchronous;
  // sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!clear_n || zero) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipo_arbiter.sv
// Round-robin arbiter granting NREQ requesters write access to one shared
// WIDTH-bit register.
//   clk     : clock, all updates on posedge
//   clear_n : synchronous active-low reset
//   req     : per-requester write request (level)
//   din     : write data, slice i = din[i*WIDTH +: WIDTH]
//   flush   : zero the shared register (honoured only in IDLE)
//   gnt     : registered one-hot grant
//   ack     : registered one-cycle write-done pulse, one-hot
//   po      : shared register contents
//   owner   : index of the last requester that wrote po
//   busy    : high whenever the FSM is not IDLE
module pipo_arbiter
  import pipo_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     clear_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    din,
  input  logic                     flush,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          ack,
  output logic [WIDTH-1:0]         po,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   win_q, win_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic            busy_q;
  logic            load, zero;
  logic [WIDTH-1:0] load_data;
  logic            rr_hit;
  logic [IW-1:0]   rr_idx;

  // Round-robin pick: scan upward from ptr, wrapping at NREQ-1 -> 0.
  always_comb begin
    int cand;
    rr_hit = 1'b0;
    rr_idx = '0;
    cand   = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!rr_hit && req[cand]) begin
        rr_hit = 1'b1;
        rr_idx = IW'(cand);
      end
    end
  end

  assign load_data = din[int'(win_q)*WIDTH +: WIDTH];

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    ptr_d   = ptr_q;
    win_d   = win_q;
    owner_d = owner_q;
    load    = 1'b0;
    zero    = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (flush) begin
          // Flush wins over arbitration for this cycle.
          zero    = 1'b1;
          owner_d = '0;
        end else if (rr_hit) begin
          win_d   = rr_idx;
          gnt_d   = ONE << rr_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        gnt_d = '0;
        if (req[win_q]) begin
          load    = 1'b1;
          owner_d = win_q;
          ack_d   = ONE << win_q;
          state_d = ACK;
        end else begin
          // Winner withdrew: abort without touching ptr so it is retried.
          state_d = IDLE;
        end
      end
      ACK: begin
        ptr_d   = (win_q == IW'(NREQ-1)) ? '0 : win_q + 1'b1;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      owner_q <= owner_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  pipo_reg #(.WIDTH(WIDTH)) u_reg (
    .clk     (clk),
    .clear_n (clear_n),
    .load    (load),
    .zero    (zero),
    .d       (load_data),
    .q       (po)
  );

  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign owner = owner_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_pipo_arbiter.sv
// Self-checking bench for pipo_arbiter. Expected writes are queued when a
// request is driven and compared whenever the DUT pulses ack.
module tb_pipo_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  logic        clk = 1'b0;
  logic        clear_n = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] din = '0;
  logic [3:0]  gnt, ack, po;
  logic [1:0]  owner;
  logic        busy;

  typedef struct {
    int         idx;
    logic [3:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  pipo_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .req     (req),
    .din     (din),
    .flush   (flush),
    .gnt     (gnt),
    .ack     (ack),
    .po      (po),
    .owner   (owner),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor plus grant/ack exclusivity, sampled on negedge.
  always @(negedge clk) begin
    exp_t e;
    n_checks++;
    if ($countones(gnt) > 1 || $countones(ack) > 1 || (gnt != 4'b0 && ack != 4'b0))
      $display("FAIL exclusive: gnt=%b ack=%b (need one-hot, not both)", gnt, ack);
    else
      n_pass++;
    if (ack !== 4'b0) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_ack: ack=%b po=%b, no write expected", ack, po);
      end else begin
        e = sb.pop_front();
        if (ack !== (4'b1 << e.idx) || po !== e.data || owner !== 2'(e.idx))
          $display("FAIL write: ack=%b po=%b owner=%0d, need ack=%b po=%b owner=%0d",
                   ack, po, owner, 4'b1 << e.idx, e.data, e.idx);
        else
          n_pass++;
      end
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic set_din(input int i, input logic [3:0] v);
    din[i*4 +: 4] = v;
  endtask

  task automatic push(input int i, input logic [3:0] v);
    exp_t e;
    e.idx  = i;
    e.data = v;
    sb.push_back(e);
  endtask

  task automatic wait_gnt(output logic [3:0] g);
    g = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (gnt !== 4'b0) begin
        g = gnt;
        break;
      end
    end
  endtask

  task automatic wait_ack;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ack !== 4'b0) break;
    end
  endtask

  task automatic do_reset;
    clear_n = 1'b0;
    tick();
    clear_n = 1'b1;
  endtask

  task automatic test_reset;
    clear_n = 1'b0;
    req = '0; flush = 1'b0; din = '0;
    tick(); tick();
    n_checks++;
    if (gnt !== 4'b0 || ack !== 4'b0) $display("FAIL reset_gnt_ack: gnt=%b ack=%b need 0000", gnt, ack);
    else n_pass++;
    n_checks++;
    if (po !== 4'b0 || owner !== 2'd0) $display("FAIL reset_po_owner: po=%b owner=%0d need 0000/0", po, owner);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: busy=%b need 0", busy);
    else n_pass++;
  endtask

  task automatic test_single;
    clear_n = 1'b1;
    req = 4'b0001;
    set_din(0, 4'b1001);
    push(0, 4'b1001);
    tick();
    n_checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1 || ack !== 4'b0)
      $display("FAIL single_gnt: gnt=%b busy=%b ack=%b need 0001/1/0000", gnt, busy, ack);
    else n_pass++;
    tick();
    n_checks++;
    if (po !== 4'b1001 || ack !== 4'b0001 || owner !== 2'd0 || gnt !== 4'b0)
      $display("FAIL single_load: po=%b ack=%b owner=%0d gnt=%b need 1001/0001/0/0000", po, ack, owner, gnt);
    else n_pass++;
    req = 4'b0000;
    tick();
    n_checks++;
    if (busy !== 1'b0 || ack !== 4'b0 || po !== 4'b1001)
      $display("FAIL single_done: busy=%b ack=%b po=%b need 0/0000/1001", busy, ack, po);
    else n_pass++;
  endtask

  task automatic test_contention;
    int ord[5] = '{0, 1, 2, 3, 0};
    logic [3:0] data[4] = '{4'b1010, 4'b1011, 4'b1110, 4'b1111};
    logic [3:0] g;
    clear_n = 1'b0;
    tick();
    clear_n = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) set_din(i, data[i]);
    for (int t = 0; t < 5; t++) push(ord[t], data[ord[t]]);
    for (int t = 0; t < 5; t++) begin
      wait_gnt(g);
      n_checks++;
      if (g !== (4'b1 << ord[t])) $display("FAIL contention_gnt%0d: gnt=%b need %b", t, g, 4'b1 << ord[t]);
      else n_pass++;
      wait_ack();
      if (t == 4) req = 4'b0000;
    end
    tick();
  endtask

  task automatic test_wrap;
    logic [3:0] g;
    do_reset();
    req = 4'b1000;
    set_din(3, 4'b0011);
    set_din(0, 4'b0101);
    push(3, 4'b0011);
    wait_gnt(g);
    n_checks++;
    if (g !== 4'b1000) $display("FAIL wrap_first: gnt=%b need 1000", g);
    else n_pass++;
    wait_ack();
    req = 4'b1001;
    push(0, 4'b0101);
    push(3, 4'b0011);
    wait_gnt(g);
    n_checks++;
    if (g !== 4'b0001) $display("FAIL wrap_second: gnt=%b need 0001", g);
    else n_pass++;
    wait_ack();
    wait_gnt(g);
    n_checks++;
    if (g !== 4'b1000) $display("FAIL wrap_third: gnt=%b need 1000", g);
    else n_pass++;
    wait_ack();
    req = 4'b0000;
    tick();
  endtask

  task automatic test_withdraw;
    logic [3:0] g;
    do_reset();
    req = 4'b0001;
    set_din(0, 4'b0110);
    push(0, 4'b0110);
    wait_gnt(g);
    wait_ack();
    req = 4'b0000;
    tick();
    req = 4'b0100;
    set_din(2, 4'b1101);
    wait_gnt(g);
    n_checks++;
    if (g !== 4'b0100) $display("FAIL withdraw_gnt: gnt=%b need 0100", g);
    else n_pass++;
    req = 4'b0000;
    tick();
    n_checks++;
    if (gnt !== 4'b0 || ack !== 4'b0 || po !== 4'b0110 || busy !== 1'b0 || owner !== 2'd0)
      $display("FAIL withdraw_abort: gnt=%b ack=%b po=%b busy=%b owner=%0d need 0000/0000/0110/0/0",
               gnt, ack, po, busy, owner);
    else n_pass++;
    req = 4'b0110;
    set_din(1, 4'b1001);
    push(1, 4'b1001);
    wait_gnt(g);
    n_checks++;
    if (g !== 4'b0010) $display("FAIL withdraw_retry: gnt=%b need 0010", g);
    else n_pass++;
    wait_ack();
    req = 4'b0000;
    tick();
  endtask

  task automatic test_flush;
    logic [3:0] g;
    do_reset();
    req = 4'b0100;
    set_din(2, 4'b1110);
    push(2, 4'b1110);
    wait_gnt(g);
    wait_ack();
    req = 4'b0000;
    tick();
    flush = 1'b1;
    req = 4'b0001;
    set_din(0, 4'b0111);
    tick();
    n_checks++;
    if (po !== 4'b0000 || owner !== 2'd0 || gnt !== 4'b0 || busy !== 1'b0)
      $display("FAIL flush_idle: po=%b owner=%0d gnt=%b busy=%b need 0000/0/0000/0", po, owner, gnt, busy);
    else n_pass++;
    flush = 1'b0;
    push(0, 4'b0111);
    wait_gnt(g);
    n_checks++;
    if (g !== 4'b0001) $display("FAIL flush_regrant: gnt=%b need 0001", g);
    else n_pass++;
    flush = 1'b1;
    tick();
    n_checks++;
    if (po !== 4'b0111 || ack !== 4'b0001)
      $display("FAIL flush_grant: po=%b ack=%b need 0111/0001", po, ack);
    else n_pass++;
    req = 4'b0000;
    tick();
    n_checks++;
    if (po !== 4'b0111 || busy !== 1'b0)
      $display("FAIL flush_ack: po=%b busy=%b need 0111/0", po, busy);
    else n_pass++;
    flush = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    logic [3:0] g;
    req = 4'b0010;
    set_din(1, 4'b1100);
    wait_gnt(g);
    n_checks++;
    if (g !== 4'b0010) $display("FAIL rstmid_gnt: gnt=%b need 0010", g);
    else n_pass++;
    clear_n = 1'b0;
    tick();
    n_checks++;
    if (gnt !== 4'b0 || ack !== 4'b0 || po !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0)
      $display("FAIL rstmid_state: gnt=%b ack=%b po=%b busy=%b owner=%0d need 0000/0000/0000/0/0",
               gnt, ack, po, busy, owner);
    else n_pass++;
    clear_n = 1'b1;
    req = 4'b0000;
    tick();
    n_checks++;
    if (ack !== 4'b0 || po !== 4'b0000)
      $display("FAIL rstmid_after: ack=%b po=%b need 0000/0000", ack, po);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_withdraw();
    test_flush();
    test_reset_mid();
    tick();
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d writes outstanding, need 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
